sensor_conditioner: RTL and testbench

//  Front end for the automatic-lighting FSM. Conditions the raw ambient (A) and

---
 rtl/sensor_conditioner.sv | 170 +++++++++++++++++
 tb/tb_sensor_conditioner.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_conditioner.sv
// Conditions the raw ambient (A) and presence (P) sensor inputs for the lighting FSM:
// per-channel synchroniser, tick-sampled debounce, clean levels, edge pulses and Ready.
module sensor_conditioner #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned DEBOUNCE_COUNT = 20
) (
    input  logic Clock,
    input  logic Reset,
    input  logic A_raw,
    input  logic P_raw,
    output logic A,
    output logic P,
    output logic A_rise,
    output logic A_fall,
    output logic P_rise,
    output logic P_fall,
    output logic Ready
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_COUNT + 1);
    localparam int unsigned NCH   = 2;

    typedef enum logic {ST_STABLE, ST_PEND} state_t;

    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic [CNT_W-1:0] r_ticks;
    logic [CNT_W-1:0] w_ticks_inc;
    logic             r_ready;
    logic [NCH-1:0]   w_raw;
    logic [NCH-1:0]   w_level;
    logic [NCH-1:0]   w_rise;
    logic [NCH-1:0]   w_fall;

    assign w_raw       = {P_raw, A_raw};
    assign w_tick      = (r_div == DIV_W'(TICK_DIV - 1));
    assign w_ticks_inc = r_ticks + CNT_W'(1);

    // Sample-tick prescaler: free-running 0..TICK_DIV-1
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Ready rises after the first full debounce window of ticks and then holds
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_ticks <= '0;
            r_ready <= 1'b0;
        end else if (w_tick && !r_ready) begin
            r_ticks <= w_ticks_inc;
            if (w_ticks_inc == CNT_W'(DEBOUNCE_COUNT)) begin
                r_ready <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;
        state_t                 r_state;
        state_t                 w_state_nxt;
        logic [CNT_W-1:0]       r_cnt;
        logic [CNT_W-1:0]       w_cnt_nxt;
        logic [CNT_W-1:0]       w_cnt_inc;
        logic                   r_level;
        logic                   w_level_nxt;
        logic                   r_rise;
        logic                   w_rise_nxt;
        logic                   r_fall;
        logic                   w_fall_nxt;
        logic                   w_commit;

        assign w_s       = r_sync[SYNC_STAGES-1];
        assign w_cnt_inc = r_cnt + CNT_W'(1);

        // Input synchroniser chain for the asynchronous raw sensor
        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
            end
        end

        // Debounce state register with registered level and edge pulses
        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_level <= w_level_nxt;
                r_rise  <= w_rise_nxt;
                r_fall  <= w_fall_nxt;
            end
        end

        // Next state: count consecutive mismatching ticks, commit at DEBOUNCE_COUNT
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_level_nxt = r_level;
            w_rise_nxt  = 1'b0;
            w_fall_nxt  = 1'b0;
            w_commit    = 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_STABLE: begin
                        if (w_s != r_level) begin
                            if (DEBOUNCE_COUNT == 1) begin
                                w_commit = 1'b1;
                            end else begin
                                w_cnt_nxt   = CNT_W'(1);
                                w_state_nxt = ST_PEND;
                            end
                        end
                    end
                    ST_PEND: begin
                        if (w_s != r_level) begin
                            if (w_cnt_inc == CNT_W'(DEBOUNCE_COUNT)) begin
                                w_commit = 1'b1;
                            end else begin
                                w_cnt_nxt = w_cnt_inc;
                            end
                        end else begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_STABLE;
                        end
                    end
                    default: begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_STABLE;
                    end
                endcase
            end
            if (w_commit) begin
                w_level_nxt = ~r_level;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_STABLE;
                w_rise_nxt  = ~r_level;
                w_fall_nxt  = r_level;
            end
        end

        assign w_level[g] = r_level;
        assign w_rise[g]  = r_rise;
        assign w_fall[g]  = r_fall;
    end

    assign A      = w_level[0];
    assign P      = w_level[1];
    assign A_rise = w_rise[0];
    assign A_fall = w_fall[0];
    assign P_rise = w_rise[1];
    assign P_fall = w_fall[1];
    assign Ready  = r_ready;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: a behavioural model pushes the expected
// output vector every clock, the driver pops and compares it on the falling edge.
module tb_sensor_conditioner;

    localparam int SYNC = 2;
    localparam int DIV  = 4;
    localparam int DC   = 3;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic A_raw = 1'b0;
    logic P_raw = 1'b0;
    logic A, P, A_rise, A_fall, P_rise, P_fall, Ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] sb_q[$];

    int n_arise, n_afall, n_prise, n_pfall;

    always #5 Clock = ~Clock;

    sensor_conditioner #(
        .SYNC_STAGES   (SYNC),
        .TICK_DIV      (DIV),
        .DEBOUNCE_COUNT(DC)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .A_raw (A_raw),
        .P_raw (P_raw),
        .A     (A),
        .P     (P),
        .A_rise(A_rise),
        .A_fall(A_fall),
        .P_rise(P_rise),
        .P_fall(P_fall),
        .Ready (Ready)
    );

    // Behavioural model: counts consecutive mismatching sampled ticks per channel
    int              m_div = 0;
    logic [SYNC-1:0] m_sync [2] = '{default: '0};
    int              m_run  [2] = '{default: 0};
    logic            m_level[2] = '{default: 1'b0};
    logic            m_rise [2] = '{default: 1'b0};
    logic            m_fall [2] = '{default: 1'b0};
    int              m_ticks = 0;
    logic            m_ready = 1'b0;
    logic            m_tick;
    logic            m_raw;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_div   = 0;
            m_ticks = 0;
            m_ready = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                m_sync[ch]  = '0;
                m_run[ch]   = 0;
                m_level[ch] = 1'b0;
                m_rise[ch]  = 1'b0;
                m_fall[ch]  = 1'b0;
            end
        end else begin
            m_tick = (m_div == DIV - 1);
            for (int ch = 0; ch < 2; ch++) begin
                m_rise[ch] = 1'b0;
                m_fall[ch] = 1'b0;
                if (m_tick) begin
                    if (m_sync[ch][SYNC-1] != m_level[ch]) begin
                        m_run[ch] = m_run[ch] + 1;
                        if (m_run[ch] == DC) begin
                            m_level[ch] = ~m_level[ch];
                            m_run[ch]   = 0;
                            if (m_level[ch]) m_rise[ch] = 1'b1;
                            else             m_fall[ch] = 1'b1;
                        end
                    end else begin
                        m_run[ch] = 0;
                    end
                end
                m_raw      = (ch == 0) ? A_raw : P_raw;
                m_sync[ch] = {m_sync[ch][SYNC-2:0], m_raw};
            end
            if (m_tick && m_ticks < DC) m_ticks = m_ticks + 1;
            m_ready = (m_ticks >= DC);
            m_div   = m_tick ? 0 : m_div + 1;
        end
        if (Clock) begin
            sb_q.push_back({m_level[0], m_level[1], m_rise[0], m_fall[0],
                            m_rise[1], m_fall[1], m_ready});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: wait for the falling edge, compare against the scoreboard, tally pulses
    task automatic step();
        logic [6:0] exp_v;
        logic [6:0] got_v;
        @(negedge Clock);
        got_v = {A, P, A_rise, A_fall, P_rise, P_fall, Ready};
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            exp_v = sb_q.pop_front();
            check("sb_out", 32'(got_v), 32'(exp_v));
        end
        if (A_rise) n_arise++;
        if (A_fall) n_afall++;
        if (P_rise) n_prise++;
        if (P_fall) n_pfall++;
    endtask

    task automatic clear_pulse_counts();
        n_arise = 0;
        n_afall = 0;
        n_prise = 0;
        n_pfall = 0;
    endtask

    int ready_at;
    int lat;
    int pr_at;
    int found;

    initial begin
        clear_pulse_counts();

        // 1: reset, then Ready after the third tick with no activity
        repeat (3) step();
        check("rst_outputs", 32'({A, P, A_rise, A_fall, P_rise, P_fall, Ready}), 32'd0);
        Reset = 1'b0;
        ready_at = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (Ready && ready_at == 0) ready_at = i;
        end
        // Third tick is sampled on the 12th edge after release; Ready shows right after it
        check("ready_cycle", 32'(ready_at), 32'd12);
        check("t1_pulses", 32'(n_arise + n_afall + n_prise + n_pfall), 32'd0);

        // 2: clean A step
        clear_pulse_counts();
        A_raw = 1'b1;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (A && lat == 0) lat = i;
        end
        check("a_seen", 32'(lat != 0), 32'd1);
        check("a_latency_le15", 32'(lat <= 15), 32'd1);
        check("a_rise_count", 32'(n_arise), 32'd1);
        check("t2_p_level", 32'(P), 32'd0);

        // 3: P glitch covering exactly two ticks is rejected
        clear_pulse_counts();
        P_raw = 1'b1;
        repeat (8) step();
        P_raw = 1'b0;
        repeat (20) step();
        check("p_glitch_level", 32'(P), 32'd0);
        check("p_glitch_pulses", 32'(n_prise + n_pfall), 32'd0);
        check("p_cnt_cleared", 32'(dut.g_ch[1].r_cnt), 32'd0);

        // 4: A falls and P rises together
        clear_pulse_counts();
        A_raw = 1'b0;
        P_raw = 1'b1;
        pr_at = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (P_rise && pr_at == 0) begin
                pr_at = i;
                check("a_fall_with_p_rise", 32'(A_fall), 32'd1);
            end
        end
        check("p_rise_seen", 32'(pr_at != 0), 32'd1);
        check("t4_a_level", 32'(A), 32'd0);
        check("t4_p_level", 32'(P), 32'd1);
        check("t4_pulse_counts", 32'({n_afall[3:0], n_prise[3:0]}), 32'h11);

        // 5: async reset while A is pending with cnt=2
        A_raw = 1'b1;
        found = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (dut.g_ch[0].r_cnt == 2) begin
                found = 1;
                break;
            end
        end
        check("a_pend_cnt2", 32'(found), 32'd1);
        #1 Reset = 1'b1;
        #1;
        check("async_rst_out", 32'({A, P, A_rise, A_fall, P_rise, P_fall, Ready}), 32'd0);
        check("async_rst_cnt", 32'(dut.g_ch[0].r_cnt), 32'd0);
        repeat (2) step();
        Reset = 1'b0;
        clear_pulse_counts();
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (A && lat == 0) lat = i;
        end
        check("a_full_redebounce", 32'(lat), 32'd12);
        check("t5_a_rise_count", 32'(n_arise), 32'd1);

        // 6: A_raw toggles every cycle; only the tick-sampled pattern matters
        for (int i = 0; i < 40; i++) begin
            A_raw = ~A_raw;
            step();
        end
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog so the bench can never hang
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
